// File: rtl/control_sequencer_pkg.sv
// Shared definitions for the control sequencer: opcodes, ALU function-select codes,
// FSM state encoding, instruction classes and control-word field positions.
package control_sequencer_pkg;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_AND = 4'h3;
    localparam logic [3:0] OP_OR  = 4'h4;
    localparam logic [3:0] OP_XOR = 4'h5;
    localparam logic [3:0] OP_NOT = 4'h6;
    localparam logic [3:0] OP_ADI = 4'h7;
    localparam logic [3:0] OP_LD  = 4'h8;
    localparam logic [3:0] OP_ST  = 4'h9;
    localparam logic [3:0] OP_BRZ = 4'hA;
    localparam logic [3:0] OP_BRN = 4'hB;
    localparam logic [3:0] OP_JMP = 4'hC;
    localparam logic [3:0] OP_ILD = 4'hD;
    localparam logic [3:0] OP_ILE = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam logic [3:0] FS_PASS = 4'b0000;
    localparam logic [3:0] FS_ADD  = 4'b0010;
    localparam logic [3:0] FS_SUB  = 4'b0101;
    localparam logic [3:0] FS_AND  = 4'b1000;
    localparam logic [3:0] FS_OR   = 4'b1001;
    localparam logic [3:0] FS_XOR  = 4'b1010;
    localparam logic [3:0] FS_NOT  = 4'b1110;

    localparam int CW_DA_LSB = 13;
    localparam int CW_AA_LSB = 10;
    localparam int CW_BA_LSB = 7;
    localparam int CW_MB_BIT = 6;
    localparam int CW_FS_LSB = 2;
    localparam int CW_MD_BIT = 1;
    localparam int CW_RW_BIT = 0;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EX1   = 2'd1,
        ST_EX2   = 2'd2,
        ST_HALT  = 2'd3
    } seq_state_t;

    typedef enum logic [3:0] {
        CLS_NOP     = 4'd0,
        CLS_ALU     = 4'd1,
        CLS_LOAD    = 4'd2,
        CLS_STORE   = 4'd3,
        CLS_BRZ     = 4'd4,
        CLS_BRN     = 4'd5,
        CLS_JMP     = 4'd6,
        CLS_HLT     = 4'd7,
        CLS_ILLEGAL = 4'd8
    } instr_class_t;

    function automatic logic [15:0] sextImm6(input logic [5:0] imm);
        return {{10{imm[5]}}, imm};
    endfunction

    function automatic logic [15:0] packCtrl(
        input logic [2:0] da,
        input logic [2:0] aa,
        input logic [2:0] ba,
        input logic       mb,
        input logic [3:0] fs,
        input logic       md,
        input logic       rw
    );
        logic [15:0] w;
        w                 = '0;
        w[CW_DA_LSB +: 3] = da;
        w[CW_AA_LSB +: 3] = aa;
        w[CW_BA_LSB +: 3] = ba;
        w[CW_MB_BIT]      = mb;
        w[CW_FS_LSB +: 4] = fs;
        w[CW_MD_BIT]      = md;
        w[CW_RW_BIT]      = rw;
        return w;
    endfunction

endpackage

// File: rtl/ctl_decode.sv
// Opcode-to-control decode: purely combinational mapping from the instruction
// register to datapath function selects, write enables and instruction class.
module ctl_decode
    import control_sequencer_pkg::*;
(
    input  logic [15:0]  ir_i,
    output logic [3:0]   fs_o,
    output logic         mb_o,
    output logic         md_o,
    output logic         rw_en_o,
    output logic         mw_en_o,
    output instr_class_t iclass_o
);

    logic [3:0]  opcode;
    logic [11:0] unused_fields;

    assign opcode        = ir_i[15:12];
    assign unused_fields = ir_i[11:0];

    always_comb begin
        fs_o     = FS_PASS;
        mb_o     = 1'b0;
        md_o     = 1'b0;
        rw_en_o  = 1'b0;
        mw_en_o  = 1'b0;
        iclass_o = CLS_NOP;
        unique case (opcode)
            OP_NOP: iclass_o = CLS_NOP;
            OP_ADD: begin fs_o = FS_ADD; rw_en_o = 1'b1; iclass_o = CLS_ALU; end
            OP_SUB: begin fs_o = FS_SUB; rw_en_o = 1'b1; iclass_o = CLS_ALU; end
            OP_AND: begin fs_o = FS_AND; rw_en_o = 1'b1; iclass_o = CLS_ALU; end
            OP_OR:  begin fs_o = FS_OR;  rw_en_o = 1'b1; iclass_o = CLS_ALU; end
            OP_XOR: begin fs_o = FS_XOR; rw_en_o = 1'b1; iclass_o = CLS_ALU; end
            OP_NOT: begin fs_o = FS_NOT; rw_en_o = 1'b1; iclass_o = CLS_ALU; end
            OP_ADI: begin
                fs_o     = FS_ADD;
                mb_o     = 1'b1;
                rw_en_o  = 1'b1;
                iclass_o = CLS_ALU;
            end
            OP_LD: begin
                md_o     = 1'b1;
                rw_en_o  = 1'b1;
                iclass_o = CLS_LOAD;
            end
            OP_ST: begin
                mw_en_o  = 1'b1;
                iclass_o = CLS_STORE;
            end
            OP_BRZ: iclass_o = CLS_BRZ;
            OP_BRN: iclass_o = CLS_BRN;
            OP_JMP: iclass_o = CLS_JMP;
            // D and E behave as NOP; the class only tells the sequencer to flag them
            OP_ILD, OP_ILE: iclass_o = CLS_ILLEGAL;
            OP_HLT: iclass_o = CLS_HLT;
            default: iclass_o = CLS_NOP;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Multi-cycle control sequencer: FETCH -> EX1 -> EX2 per instruction, with a HALT
// state released by Go. Drives the datapath control word and program counter.
module control_sequencer
    import control_sequencer_pkg::*;
(
    input  logic        CLK,
    input  logic        RESET,
    input  logic [15:0] Instr,
    input  logic        V,
    input  logic        C,
    input  logic        N,
    input  logic        Z,
    input  logic [15:0] Adrin,
    input  logic        Go,
    output logic [15:0] PC,
    output logic [15:0] CTRWRD,
    output logic [15:0] Cin,
    output logic        MW,
    output logic        Halted,
    output logic        Illegal
);

    seq_state_t   state_q, state_d;
    logic [15:0]  pc_q, pc_d;
    logic [15:0]  ir_q, ir_d;
    logic         illegal_q, illegal_d;

    logic [3:0]   dec_fs;
    logic         dec_mb;
    logic         dec_md;
    logic         dec_rw_en;
    logic         dec_mw_en;
    instr_class_t dec_class;

    logic [15:0]  pc_plus_one;
    logic [15:0]  pc_branch;
    logic [15:0]  pc_after_ex2;
    logic         in_exec;
    logic         unused_flags;

    // Overflow and carry play no part in sequencing.
    assign unused_flags = V ^ C;

    ctl_decode u_decode (
        .ir_i     (ir_q),
        .fs_o     (dec_fs),
        .mb_o     (dec_mb),
        .md_o     (dec_md),
        .rw_en_o  (dec_rw_en),
        .mw_en_o  (dec_mw_en),
        .iclass_o (dec_class)
    );

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q   <= ST_FETCH;
            pc_q      <= 16'h0000;
            ir_q      <= 16'h0000;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            illegal_q <= illegal_d;
        end
    end

    assign pc_plus_one = pc_q + 16'd1;
    assign pc_branch   = pc_plus_one + sextImm6(ir_q[5:0]);

    // Flags are consulted only while in EX2, which is the only place this is used.
    always_comb begin
        pc_after_ex2 = pc_plus_one;
        unique case (dec_class)
            CLS_BRZ: pc_after_ex2 = Z ? pc_branch : pc_plus_one;
            CLS_BRN: pc_after_ex2 = N ? pc_branch : pc_plus_one;
            CLS_JMP: pc_after_ex2 = Adrin;
            CLS_HLT: pc_after_ex2 = pc_q;
            default: pc_after_ex2 = pc_plus_one;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        illegal_d = illegal_q;
        unique case (state_q)
            ST_FETCH: begin
                ir_d    = Instr;
                state_d = ST_EX1;
            end
            ST_EX1: state_d = ST_EX2;
            ST_EX2: begin
                pc_d    = pc_after_ex2;
                state_d = (dec_class == CLS_HLT) ? ST_HALT : ST_FETCH;
                if (dec_class == CLS_ILLEGAL) begin
                    illegal_d = 1'b1;
                end
            end
            ST_HALT: begin
                if (Go) begin
                    state_d = ST_FETCH;
                end
            end
            default: state_d = ST_FETCH;
        endcase
    end

    // Outputs decode only registered state and IR, never the live Instr bus.
    assign in_exec = (state_q == ST_EX1) || (state_q == ST_EX2);

    always_comb begin
        CTRWRD = 16'h0000;
        Cin    = 16'h0000;
        MW     = 1'b0;
        if (in_exec) begin
            CTRWRD = packCtrl(ir_q[11:9], ir_q[8:6], ir_q[5:3], dec_mb, dec_fs, dec_md,
                              dec_rw_en && (state_q == ST_EX2));
            Cin    = {10'b0, ir_q[5:0]};
            MW     = dec_mw_en && (state_q == ST_EX2);
        end
    end

    assign PC      = pc_q;
    assign Halted  = (state_q == ST_HALT);
    assign Illegal = illegal_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: a per-instruction reference model pushes
// expected per-cycle outputs into a queue; a negedge monitor pops and compares.
module tb_control_sequencer;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [15:0] Instr;
    logic        V, C, N, Z;
    logic [15:0] Adrin;
    logic        Go;
    logic [15:0] PC, CTRWRD, Cin;
    logic        MW, Halted, Illegal;

    typedef struct {
        logic [15:0] ctrwrd;
        logic [15:0] cin;
        logic [15:0] pc;
        logic        mw;
        logic        halted;
        logic        illegal;
        string       tag;
    } exp_t;

    exp_t        expQ[$];
    exp_t        monExp;
    int          checks   = 0;
    int          failures = 0;
    logic [15:0] mPc;
    logic        mIll;

    control_sequencer dut (
        .CLK     (CLK),
        .RESET   (RESET),
        .Instr   (Instr),
        .V       (V),
        .C       (C),
        .N       (N),
        .Z       (Z),
        .Adrin   (Adrin),
        .Go      (Go),
        .PC      (PC),
        .CTRWRD  (CTRWRD),
        .Cin     (Cin),
        .MW      (MW),
        .Halted  (Halted),
        .Illegal (Illegal)
    );

    always #5 CLK = ~CLK;

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h at t=%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge CLK) begin
        if (expQ.size() > 0) begin
            monExp = expQ.pop_front();
            checkOutput({monExp.tag, ".ctrwrd"},  CTRWRD,        monExp.ctrwrd);
            checkOutput({monExp.tag, ".cin"},     Cin,           monExp.cin);
            checkOutput({monExp.tag, ".pc"},      PC,            monExp.pc);
            checkOutput({monExp.tag, ".mw"},      16'(MW),       16'(monExp.mw));
            checkOutput({monExp.tag, ".halted"},  16'(Halted),   16'(monExp.halted));
            checkOutput({monExp.tag, ".illegal"}, 16'(Illegal),  16'(monExp.illegal));
        end
    end

    // Outputs expected while no instruction is executing (FETCH or HALT).
    function automatic exp_t idleExp(input string tag, input logic halted);
        exp_t e;
        e.ctrwrd  = 16'h0000;
        e.cin     = 16'h0000;
        e.pc      = mPc;
        e.mw      = 1'b0;
        e.halted  = halted;
        e.illegal = mIll;
        e.tag     = tag;
        return e;
    endfunction

    // Control word built from the opcode table with field weights as plain arithmetic.
    function automatic exp_t execExp(input string tag, input logic [15:0] ir, input bit ex2);
        exp_t e;
        int op = int'(ir[15:12]);
        int fs = 0, mb = 0, md = 0, rw = 0, word;
        case (op)
            1: begin fs = 2;  rw = 1; end
            2: begin fs = 5;  rw = 1; end
            3: begin fs = 8;  rw = 1; end
            4: begin fs = 9;  rw = 1; end
            5: begin fs = 10; rw = 1; end
            6: begin fs = 14; rw = 1; end
            7: begin fs = 2;  mb = 1; rw = 1; end
            8: begin md = 1;  rw = 1; end
            default: ;
        endcase
        word = int'(ir[11:9]) * 8192 + int'(ir[8:6]) * 1024 + int'(ir[5:3]) * 128
             + mb * 64 + fs * 4 + md * 2 + (ex2 ? rw : 0);
        e.ctrwrd  = 16'(word);
        e.cin     = 16'(int'(ir[5:0]));
        e.pc      = mPc;
        e.mw      = ex2 && (op == 9);
        e.halted  = 1'b0;
        e.illegal = mIll;
        e.tag     = tag;
        return e;
    endfunction

    task automatic nextCycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic randomizeSide();
        V     = 1'($urandom);
        C     = 1'($urandom);
        N     = 1'($urandom);
        Z     = 1'($urandom);
        Adrin = 16'($urandom);
        Go    = 1'($urandom);
    endtask

    task automatic applyStimulus(input string tag, input logic [15:0] instr, input bit z,
                                 input bit n, input logic [15:0] adr, input int haltCycles,
                                 input bit resetInEx2);
        int op = int'(instr[15:12]);
        int imm = int'(instr[5:0]);
        int nxt;
        if (imm >= 32) imm -= 64;

        randomizeSide();
        Instr = instr;
        expQ.push_back(idleExp({tag, ".fetch"}, 1'b0));
        nextCycle();

        randomizeSide();
        Instr = 16'($urandom);
        expQ.push_back(execExp({tag, ".ex1"}, instr, 1'b0));
        nextCycle();

        randomizeSide();
        Instr = 16'($urandom);
        Z     = z;
        N     = n;
        Adrin = adr;
        expQ.push_back(execExp({tag, ".ex2"}, instr, 1'b1));

        if (resetInEx2) begin
            @(negedge CLK);
            #1;
            RESET = 1'b1;
            #1;
            checkOutput({tag, ".rst.mw"},     16'(MW),     16'h0000);
            checkOutput({tag, ".rst.pc"},     PC,          16'h0000);
            checkOutput({tag, ".rst.ctrwrd"}, CTRWRD,      16'h0000);
            checkOutput({tag, ".rst.cin"},    Cin,         16'h0000);
            checkOutput({tag, ".rst.halted"}, 16'(Halted), 16'h0000);
            nextCycle();
            RESET = 1'b0;
            mPc   = 16'h0000;
            mIll  = 1'b0;
            return;
        end

        case (op)
            10: nxt = z ? int'(mPc) + 1 + imm : int'(mPc) + 1;
            11: nxt = n ? int'(mPc) + 1 + imm : int'(mPc) + 1;
            12: nxt = int'(adr);
            15: nxt = int'(mPc);
            default: nxt = int'(mPc) + 1;
        endcase
        nextCycle();
        mPc = 16'(nxt & 32'hFFFF);
        if (op == 13 || op == 14) mIll = 1'b1;

        if (op == 15) begin
            for (int i = 0; i < haltCycles; i++) begin
                randomizeSide();
                Go    = 1'b0;
                Instr = 16'($urandom);
                expQ.push_back(idleExp({tag, ".halt"}, 1'b1));
                nextCycle();
            end
            randomizeSide();
            Go = 1'b1;
            expQ.push_back(idleExp({tag, ".go"}, 1'b1));
            nextCycle();
            Go = 1'b0;
        end
    endtask

    task automatic pulseReset(input string tag);
        RESET = 1'b1;
        #1;
        checkOutput({tag, ".pc"},      PC,           16'h0000);
        checkOutput({tag, ".illegal"}, 16'(Illegal), 16'h0000);
        checkOutput({tag, ".ctrwrd"},  CTRWRD,       16'h0000);
        nextCycle();
        RESET = 1'b0;
        mPc   = 16'h0000;
        mIll  = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog expired actual=running required=finished");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [15:0] rInstr;
        RESET = 1'b1;
        Instr = 16'h0000;
        {V, C, N, Z} = 4'b0000;
        Adrin = 16'h0000;
        Go    = 1'b0;
        mPc   = 16'h0000;
        mIll  = 1'b0;
        #2;
        checkOutput("reset.pc",      PC,           16'h0000);
        checkOutput("reset.ctrwrd",  CTRWRD,       16'h0000);
        checkOutput("reset.cin",     Cin,          16'h0000);
        checkOutput("reset.mw",      16'(MW),      16'h0000);
        checkOutput("reset.halted",  16'(Halted),  16'h0000);
        checkOutput("reset.illegal", 16'(Illegal), 16'h0000);
        nextCycle();
        nextCycle();
        RESET = 1'b0;

        applyStimulus("add",     16'h1650, 1'b0, 1'b0, 16'h0000, 0, 1'b0);
        applyStimulus("adi",     16'h723F, 1'b0, 1'b0, 16'h0000, 0, 1'b0);
        applyStimulus("jmp5a",   16'hC000, 1'b0, 1'b0, 16'h0005, 0, 1'b0);
        applyStimulus("brzTak",  16'hA03E, 1'b1, 1'b0, 16'h1234, 0, 1'b0);
        applyStimulus("jmp5b",   16'hC000, 1'b0, 1'b0, 16'h0005, 0, 1'b0);
        applyStimulus("brzNot",  16'hA03E, 1'b0, 1'b1, 16'h1234, 0, 1'b0);
        applyStimulus("jmp5c",   16'hC000, 1'b0, 1'b0, 16'h0005, 0, 1'b0);
        applyStimulus("brnTak",  16'hB03E, 1'b0, 1'b1, 16'h1234, 0, 1'b0);
        applyStimulus("jmpTop",  16'hC040, 1'b0, 1'b0, 16'hFFFF, 0, 1'b0);
        applyStimulus("wrap",    16'h0000, 1'b0, 1'b0, 16'h0000, 0, 1'b0);
        applyStimulus("st",      16'h9288, 1'b0, 1'b0, 16'h0000, 0, 1'b0);
        applyStimulus("ld",      16'h8A40, 1'b0, 1'b0, 16'h0000, 0, 1'b0);
        applyStimulus("stRst",   16'h9288, 1'b0, 1'b0, 16'h0000, 0, 1'b1);
        applyStimulus("hlt",     16'hF000, 1'b0, 1'b0, 16'h0000, 10, 1'b0);
        applyStimulus("ill",     16'hD123, 1'b0, 1'b0, 16'h0000, 0, 1'b0);
        applyStimulus("postIll", 16'h1650, 1'b0, 1'b0, 16'h0000, 0, 1'b0);
        applyStimulus("illE",    16'hE1FF, 1'b0, 1'b0, 16'h0000, 0, 1'b0);

        for (int i = 0; i < 300; i++) begin
            rInstr = 16'($urandom);
            applyStimulus("rand", rInstr, 1'($urandom), 1'($urandom), 16'($urandom),
                          int'($urandom_range(0, 3)), 1'b0);
        end

        pulseReset("finalRst");
        applyStimulus("afterRst", 16'h5E28, 1'b0, 1'b0, 16'h0000, 0, 1'b0);

        @(negedge CLK);
        #1;
        checkOutput("queueDrained", 16'(expQ.size()), 16'h0000);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
